// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit words from qualified
// serial bits and offers each word on a one-entry valid/ready output buffer.
// A word that completes while the buffer is full and not draining is dropped
// and flagged by the sticky overrun output.
module sipo_deser #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   sin,
   input  logic                   sin_valid,
   output logic [WIDTH-1:0]       dout,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic [$clog2(WIDTH):0] bit_cnt,
   output logic                   overrun
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } buf_state_t;

   buf_state_t       r_state;
   buf_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dout;
   logic             r_ovr;
   logic             w_complete;
   logic             w_handshake;
   logic             w_load;
   logic             w_drop;

   // Edge that samples the last bit of a word, and a live output transfer.
   assign w_complete  = sin_valid && (r_cnt == CW'(WIDTH - 1));
   assign w_handshake = (r_state == ST_FULL) && dout_ready;

   // Shift register contents after accepting sin, in the configured bit order.
   always_comb begin
      w_shift_nxt = r_shift;
      if (MSB_FIRST) begin
         w_shift_nxt = {r_shift[WIDTH-2:0], sin};
      end else begin
         w_shift_nxt = {sin, r_shift[WIDTH-1:1]};
      end
   end

   // Output buffer state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Output buffer next state; clear wins over everything on its edge.
   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_complete) w_state_nxt = ST_FULL;
            ST_FULL:  if (w_handshake && !w_complete) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Buffer load / drop decisions for a completing word.
   always_comb begin
      w_load = 1'b0;
      w_drop = 1'b0;
      if (!clear && w_complete) begin
         case (r_state)
            ST_EMPTY: w_load = 1'b1;
            ST_FULL: begin
               w_load = dout_ready;
               w_drop = !dout_ready;
            end
            default: w_load = 1'b0;
         endcase
      end
   end

   // Datapath: shift register, bit counter, held word and sticky overrun.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_dout  <= '0;
         r_ovr   <= 1'b0;
      end else if (clear) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_dout  <= '0;
         r_ovr   <= 1'b0;
      end else begin
         if (sin_valid) begin
            r_shift <= w_shift_nxt;
            r_cnt   <= w_complete ? '0 : CW'(r_cnt + 1'b1);
         end
         if (w_load) begin
            r_dout <= w_shift_nxt;
         end
         if (w_drop) begin
            r_ovr <= 1'b1;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = (r_state == ST_FULL);
   assign bit_cnt    = r_cnt;
   assign overrun    = r_ovr;

endmodule

// File: tb/tb_sipo_deser.sv
// Testbench for sipo_deser: one MSB-first and one LSB-first instance share
// the same stimulus; a bit-list reference model feeds a word scoreboard that
// an independent monitor drains on every output handshake.
module tb_sipo_deser;

   localparam int unsigned W = 4;

   logic         clk        = 1'b0;
   logic         rst        = 1'b1;
   logic         clear      = 1'b0;
   logic         sin        = 1'b0;
   logic         sin_valid  = 1'b0;
   logic         dout_ready = 1'b0;

   logic [W-1:0] dout_m, dout_l;
   logic         dv_m, dv_l, ov_m, ov_l;
   logic [2:0]   bc_m, bc_l;

   int total = 0;
   int bad   = 0;
   bit run   = 1'b0;

   // Reference model state: bits of the partial word, buffer flag, overrun.
   bit           q_bits[$];
   bit           m_valid = 1'b0;
   bit           m_ovr   = 1'b0;
   logic [W-1:0] exp_m[$];
   logic [W-1:0] exp_l[$];

   sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .clear(clear), .sin(sin), .sin_valid(sin_valid),
      .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
      .bit_cnt(bc_m), .overrun(ov_m)
   );

   sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .clear(clear), .sin(sin), .sin_valid(sin_valid),
      .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
      .bit_cnt(bc_l), .overrun(ov_l)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q_bits.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      exp_m.delete();
      exp_l.delete();
   endtask

   // Effect of one rising edge on the model, given the inputs held at it.
   task automatic model_edge(input bit v, input bit s, input bit r, input bit c);
      logic [W-1:0] wm;
      logic [W-1:0] wl;
      if (c) begin
         model_reset();
         return;
      end
      if (m_valid && r) m_valid = 1'b0;
      if (v) begin
         q_bits.push_back(s);
         if (q_bits.size() == W) begin
            for (int i = 0; i < W; i++) begin
               wm[W-1-i] = q_bits[i];
               wl[i]     = q_bits[i];
            end
            q_bits.delete();
            if (!m_valid) begin
               m_valid = 1'b1;
               exp_m.push_back(wm);
               exp_l.push_back(wl);
            end else begin
               m_ovr = 1'b1;
            end
         end
      end
   endtask

   // One clock: drive inputs, wait for the edge, advance the model.
   task automatic cyc(input bit v, input bit s, input bit r, input bit c);
      sin_valid  = v;
      sin        = s;
      dout_ready = r;
      clear      = c;
      @(posedge clk);
      #2;
      model_edge(v, s, r, c);
   endtask

   // Send a word first-bit-first from w[W-1] down to w[0].
   task automatic send_word(input logic [W-1:0] w, input bit rdy_last, input bit rdy_other);
      for (int i = W - 1; i >= 0; i--) begin
         cyc(1'b1, w[i], (i == 0) ? rdy_last : rdy_other, 1'b0);
      end
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_rst();
      #1 rst = 1'b0;
      #1;
      chk("async_rst_dout_msb", dout_m, 0);
      chk("async_rst_dout_lsb", dout_l, 0);
      chk("async_rst_valid", dv_m | dv_l, 0);
      chk("async_rst_bitcnt", bc_m | bc_l, 0);
      chk("async_rst_overrun", ov_m | ov_l, 0);
      model_reset();
      rst = 1'b1;
   endtask

   // Monitor: compare DUT against model mid-cycle, pop words on handshake.
   always @(negedge clk) begin
      if (run) begin
         if (!rst) begin
            chk("rst_dout", dout_m | dout_l, 0);
            chk("rst_valid", dv_m | dv_l, 0);
            chk("rst_bitcnt", bc_m | bc_l, 0);
            chk("rst_overrun", ov_m | ov_l, 0);
         end else begin
            chk("valid_msb", dv_m, m_valid);
            chk("valid_lsb", dv_l, m_valid);
            chk("bitcnt_msb", bc_m, q_bits.size());
            chk("bitcnt_lsb", bc_l, q_bits.size());
            chk("overrun_msb", ov_m, m_ovr);
            chk("overrun_lsb", ov_l, m_ovr);
            if (dv_m) begin
               if (exp_m.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_msb: word %h presented with none expected at %0t", dout_m, $time);
               end else begin
                  chk("sb_msb", dout_m, exp_m[0]);
                  if (dout_ready && !clear) void'(exp_m.pop_front());
               end
            end
            if (dv_l) begin
               if (exp_l.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_lsb: word %h presented with none expected at %0t", dout_l, $time);
               end else begin
                  chk("sb_lsb", dout_l, exp_l[0]);
                  if (dout_ready && !clear) void'(exp_l.pop_front());
               end
            end
         end
      end
   end

   initial begin
      run = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      model_reset();
      rst = 1'b1;

      // Basic MSB-first word, one-cycle valid pulse with ready high.
      send_word(4'b1011, 1'b1, 1'b1);
      chk("basic_dout", dout_m, 4'b1011);
      chk("basic_valid", dv_m, 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("basic_valid_drop", dv_m, 0);

      // LSB-first with 3-cycle gaps between bits.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, (i < 2) ? 1'b1 : 1'b0, 1'b1, 1'b0);
         if (i < 3) repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk("lsb_gap_dout", dout_l, 4'b0011);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);

      // Backpressure: second word dropped, overrun sticky until clear.
      send_word(4'hA, 1'b0, 1'b0);
      send_word(4'h5, 1'b0, 1'b0);
      chk("ovr_dout_held", dout_m, 4'hA);
      chk("ovr_valid", dv_m, 1);
      chk("ovr_flag", ov_m, 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("ovr_drain_valid", dv_m, 0);
      chk("ovr_sticky", ov_m, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovr_cleared", ov_m, 0);

      // Drain and load on the same edge.
      send_word(4'h3, 1'b0, 1'b0);
      send_word(4'hC, 1'b1, 1'b0);
      chk("simul_dout", dout_m, 4'hC);
      chk("simul_valid", dv_m, 1);
      chk("simul_overrun", ov_m, 0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);

      // Mid-word asynchronous reset, then a fresh word.
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      pulse_rst();
      send_word(4'hF, 1'b1, 1'b1);
      chk("rst_mid_word_msb", dout_m, 4'hF);
      chk("rst_mid_word_lsb", dout_l, 4'hF);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);

      // Same abort using synchronous clear.
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      send_word(4'hF, 1'b1, 1'b1);
      chk("clr_mid_word_msb", dout_m, 4'hF);
      chk("clr_mid_word_lsb", dout_l, 4'hF);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic with backpressure, clears and reset pulses.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) pulse_rst();
         cyc($urandom_range(0, 9) < 6, 1'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 49) == 0);
      end
      repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);

      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
